// File: rtl/branch_resolver_pkg.sv
// Shared opcode encodings and FSM state type for the branch resolver.
package branch_resolver_pkg;

    localparam int OPCODE_W = 4;
    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_CMP = 4'h1;
    localparam opcode_t OP_BEQ = 4'h8;
    localparam opcode_t OP_BNE = 4'h9;
    localparam opcode_t OP_BLT = 4'hA;
    localparam opcode_t OP_BGE = 4'hB;
    localparam opcode_t OP_JMP = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Decode-side branch request, fetch-side redirect and pipeline control signals.
interface branch_resolver_if
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
);
    logic                   br_valid;
    logic                   br_ready;
    opcode_t                opcode;
    logic                   zero;
    logic                   is_less_than;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  offset;
    logic                   redirect_valid;
    logic                   redirect_ready;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   flush;
    logic                   stall;
    logic [COUNT_WIDTH-1:0] taken_count;

    modport master (
        output br_valid, opcode, zero, is_less_than, pc, offset, redirect_ready,
        input  br_ready, redirect_valid, redirect_pc, flush, stall, taken_count
    );

    modport slave (
        input  br_valid, opcode, zero, is_less_than, pc, offset, redirect_ready,
        output br_ready, redirect_valid, redirect_pc, flush, stall, taken_count
    );
endinterface

// File: rtl/branch_resolver_condition.sv
// Combinational branch condition: decides taken from opcode and comparator flags.
module branch_condition
    import branch_resolver_pkg::*;
(
    input  opcode_t opcode,
    input  logic    zero,
    input  logic    is_less_than,
    output logic    taken
);
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = !zero;
            OP_BLT:  taken = is_less_than;
            OP_BGE:  taken = !is_less_than;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolver.sv
// Resolves branches, redirects fetch on taken ones, then holds a fixed-length flush.
//   state      | meaning
//   S_IDLE     | ready for a branch; not-taken branches retire with no bubble
//   S_REDIRECT | redirect_valid up, redirect_pc held until fetch accepts
//   S_FLUSH    | flush held while the flush counter runs down to 1
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_WIDTH  = 16
)(
    input logic               clk,
    input logic               reset,
    branch_resolver_if.slave  bus
);
    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  target_q, target_d;
    logic [FC_W-1:0]        fcnt_q, fcnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   taken;

    branch_condition u_cond (
        .opcode       (bus.opcode),
        .zero         (bus.zero),
        .is_less_than (bus.is_less_than),
        .taken        (taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            fcnt_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            fcnt_q   <= fcnt_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        target_d           = target_q;
        fcnt_d             = fcnt_q;
        count_d            = count_q;
        bus.br_ready       = 1'b0;
        bus.stall          = 1'b1;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.br_ready = 1'b1;
                bus.stall    = 1'b0;
                // Not-taken and non-branch opcodes are accepted without touching any state.
                if (bus.br_valid && taken) begin
                    state_d  = S_REDIRECT;
                    target_d = bus.pc + bus.offset;
                    if (count_q != '1)
                        count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            S_REDIRECT: begin
                bus.redirect_valid = 1'b1;
                if (bus.redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FLUSH;
                        fcnt_d  = FC_LOAD;
                    end
                end
            end
            S_FLUSH: begin
                bus.flush = 1'b1;
                fcnt_d    = fcnt_q - FC_W'(1);
                if (fcnt_q <= FC_W'(1)) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.redirect_pc = target_q;
    assign bus.taken_count = count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench: directed vector table, hand sequences, and randomized run vs. model.
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;

    branch_resolver_if #(.ADDR_WIDTH(16), .COUNT_WIDTH(16)) bus_a ();
    branch_resolver_if #(.ADDR_WIDTH(16), .COUNT_WIDTH(2))  bus_b ();

    branch_resolver #(.ADDR_WIDTH(16), .FLUSH_CYCLES(2), .COUNT_WIDTH(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    branch_resolver #(.ADDR_WIDTH(16), .FLUSH_CYCLES(2), .COUNT_WIDTH(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        opcode_t     op;
        logic        z;
        logic        lt;
        logic [15:0] pc;
        logic [15:0] off;
        logic        exp_taken;
        logic [15:0] exp_tgt;
    } vec_t;

    vec_t vecs[12];

    // Model state for the randomized run
    bit          m_pending;
    int          m_flush;
    logic [15:0] m_target;
    int          m_cnt_a;
    int          m_cnt_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input opcode_t op, input logic z, input logic lt,
                         input logic [15:0] pc, input logic [15:0] off, input logic rr);
        bus_a.br_valid = v;  bus_b.br_valid = v;
        bus_a.opcode = op;   bus_b.opcode = op;
        bus_a.zero = z;      bus_b.zero = z;
        bus_a.is_less_than = lt; bus_b.is_less_than = lt;
        bus_a.pc = pc;       bus_b.pc = pc;
        bus_a.offset = off;  bus_b.offset = off;
        bus_a.redirect_ready = rr; bus_b.redirect_ready = rr;
    endtask

    task automatic drain(input int n);
        drive(1'b0, OP_CMP, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, OP_CMP, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {bus_a.br_ready, bus_a.stall, bus_a.flush, bus_a.redirect_valid,
               bus_a.redirect_pc, bus_a.taken_count},
              {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
        check("reset_count_b", 64'(bus_b.taken_count), 64'd0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    function automatic bit ref_taken(input opcode_t op, input logic z, input logic lt);
        if (op == OP_JMP) return 1'b1;
        if (op == OP_BEQ) return z;
        if (op == OP_BNE) return !z;
        if (op == OP_BLT) return lt;
        if (op == OP_BGE) return !lt;
        return 1'b0;
    endfunction

    initial begin
        int          exp_cnt;
        logic [15:0] last_tgt;
        opcode_t     op_pool[8];
        n_checks = 0;
        n_err    = 0;

        vecs[0]  = '{OP_BEQ, 1'b1, 1'b0, 16'h0010, 16'h0008, 1'b1, 16'h0018};
        vecs[1]  = '{OP_BNE, 1'b1, 1'b0, 16'h0020, 16'h0008, 1'b0, 16'h0000};
        vecs[2]  = '{OP_BGE, 1'b0, 1'b0, 16'h0100, 16'h0010, 1'b1, 16'h0110};
        vecs[3]  = '{OP_JMP, 1'b0, 1'b1, 16'hFFFE, 16'h0004, 1'b1, 16'h0002};
        vecs[4]  = '{OP_JMP, 1'b1, 1'b0, 16'h0010, 16'hFFF0, 1'b1, 16'h0000};
        vecs[5]  = '{OP_BLT, 1'b0, 1'b1, 16'h1234, 16'h0100, 1'b1, 16'h1334};
        vecs[6]  = '{OP_BLT, 1'b1, 1'b0, 16'h0040, 16'h0004, 1'b0, 16'h0000};
        vecs[7]  = '{OP_BEQ, 1'b0, 1'b1, 16'h0050, 16'h0004, 1'b0, 16'h0000};
        vecs[8]  = '{OP_BNE, 1'b0, 1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0000};
        vecs[9]  = '{OP_BGE, 1'b1, 1'b1, 16'h0060, 16'h0004, 1'b0, 16'h0000};
        vecs[10] = '{OP_CMP, 1'b1, 1'b1, 16'h0070, 16'h0004, 1'b0, 16'h0000};
        vecs[11] = '{4'hF,   1'b0, 1'b0, 16'h0080, 16'h0004, 1'b0, 16'h0000};

        reset = 1'b0;
        drive(1'b0, OP_CMP, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        do_reset();

        // Directed vector table
        exp_cnt  = 0;
        last_tgt = 16'h0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].z, vecs[i].lt, vecs[i].pc, vecs[i].off, 1'b1);
            @(negedge clk);
            drive(1'b0, OP_CMP, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
            if (vecs[i].exp_taken) begin
                exp_cnt++;
                last_tgt = vecs[i].exp_tgt;
                check($sformatf("vec%0d_redirect", i),
                      {bus_a.redirect_valid, bus_a.redirect_pc, bus_a.stall, bus_a.br_ready, bus_a.flush},
                      {1'b1, vecs[i].exp_tgt, 1'b1, 1'b0, 1'b0});
                @(negedge clk);
                check($sformatf("vec%0d_flush1", i),
                      {bus_a.flush, bus_a.redirect_valid, bus_a.br_ready}, {1'b1, 1'b0, 1'b0});
                @(negedge clk);
                check($sformatf("vec%0d_flush2", i),
                      {bus_a.flush, bus_a.br_ready}, {1'b1, 1'b0});
                @(negedge clk);
                check($sformatf("vec%0d_ready_again", i),
                      {bus_a.flush, bus_a.br_ready, bus_a.stall}, {1'b0, 1'b1, 1'b0});
            end else begin
                check($sformatf("vec%0d_not_taken", i),
                      {bus_a.redirect_valid, bus_a.br_ready, bus_a.stall, bus_a.flush, bus_a.redirect_pc},
                      {1'b0, 1'b1, 1'b0, 1'b0, last_tgt});
            end
            check($sformatf("vec%0d_count", i), 64'(bus_a.taken_count), 64'(exp_cnt));
            check($sformatf("vec%0d_count_b", i), 64'(bus_b.taken_count),
                  64'((exp_cnt > 3) ? 3 : exp_cnt));
        end

        // Back-to-back: not-taken BNE then taken BGE on the very next cycle
        do_reset();
        drive(1'b1, OP_BNE, 1'b1, 1'b0, 16'h0300, 16'h0010, 1'b1);
        @(negedge clk);
        check("b2b_bne_idle", {bus_a.br_ready, bus_a.redirect_valid, bus_a.flush}, {1'b1, 1'b0, 1'b0});
        drive(1'b1, OP_BGE, 1'b1, 1'b0, 16'h0200, 16'h0004, 1'b1);
        @(negedge clk);
        check("b2b_bge_taken", {bus_a.redirect_valid, bus_a.redirect_pc, bus_a.taken_count},
              {1'b1, 16'h0204, 16'd1});
        drain(3);

        // Backpressure: redirect held for 5 cycles, br_valid pulses ignored
        drive(1'b1, OP_BLT, 1'b0, 1'b1, 16'h0100, 16'h0020, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i),
                  {bus_a.redirect_valid, bus_a.redirect_pc, bus_a.stall, bus_a.flush, bus_a.br_ready,
                   bus_a.taken_count},
                  {1'b1, 16'h0120, 1'b1, 1'b0, 1'b0, 16'd2});
            drive(1'(i % 2 == 0), OP_JMP, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
            @(negedge clk);
        end
        drain(1);
        check("bp_flush_start", {bus_a.flush, bus_a.redirect_valid, bus_a.taken_count},
              {1'b1, 1'b0, 16'd2});
        drain(2);
        check("bp_idle", {bus_a.br_ready, bus_a.flush}, {1'b1, 1'b0});

        // Reset in the second REDIRECT cycle takes effect without a clock edge
        drive(1'b1, OP_BEQ, 1'b1, 1'b0, 16'h0500, 16'h0100, 1'b0);
        @(negedge clk);
        drive(1'b0, OP_CMP, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("rst_mid_redirect1", 64'(bus_a.redirect_valid), 64'd1);
        @(negedge clk);
        check("rst_mid_redirect2", 64'(bus_a.redirect_valid), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_async_outputs",
              {bus_a.redirect_valid, bus_a.redirect_pc, bus_a.flush, bus_a.br_ready, bus_a.stall,
               bus_a.taken_count, bus_b.taken_count},
              {1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'd0, 2'd0});
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, OP_BEQ, 1'b1, 1'b0, 16'h0030, 16'h0010, 1'b1);
        @(negedge clk);
        check("rst_then_beq", {bus_a.redirect_valid, bus_a.redirect_pc, bus_a.taken_count},
              {1'b1, 16'h0040, 16'd1});
        drain(3);

        // Saturation on the 2-bit counter instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_JMP, 1'b0, 1'b0, 16'(i * 16), 16'h0004, 1'b1);
            @(negedge clk);
            drain(3);
        end
        check("sat_count_b", 64'(bus_b.taken_count), 64'd3);
        check("sat_count_a", 64'(bus_a.taken_count), 64'd5);
        drive(1'b1, 4'hE, 1'b1, 1'b1, 16'h0900, 16'h0004, 1'b1);
        @(negedge clk);
        drive(1'b0, OP_CMP, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        check("nonbranch_accept",
              {bus_a.br_ready, bus_a.redirect_valid, bus_a.taken_count, bus_b.taken_count},
              {1'b1, 1'b0, 16'd5, 2'd3});

        // Randomized run against the transaction-level model
        do_reset();
        m_pending = 1'b0;
        m_flush   = 0;
        m_target  = 16'h0;
        m_cnt_a   = 0;
        m_cnt_b   = 0;
        op_pool   = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JMP, OP_CMP, 4'h0, 4'hF};
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        v, z, lt, rr;
            opcode_t     op;
            logic [15:0] pc, off;
            bit          exp_ready;
            exp_ready = !m_pending && (m_flush == 0);
            check("rnd_outputs",
                  {bus_a.br_ready, bus_a.stall, bus_a.flush, bus_a.redirect_valid,
                   bus_a.redirect_pc, bus_a.taken_count},
                  {exp_ready, !exp_ready, (m_flush > 0), m_pending, m_target, 16'(m_cnt_a)});
            check("rnd_count_b", 64'(bus_b.taken_count), 64'(m_cnt_b));
            v   = 1'($urandom_range(0, 1));
            op  = op_pool[$urandom_range(0, 7)];
            z   = 1'($urandom_range(0, 1));
            lt  = 1'($urandom_range(0, 1));
            pc  = 16'($urandom);
            off = 16'($urandom);
            rr  = ($urandom_range(0, 9) < 6);
            drive(v, op, z, lt, pc, off, rr);
            if (m_pending) begin
                if (rr) begin
                    m_pending = 1'b0;
                    m_flush   = 2;
                end
            end else if (m_flush > 0) begin
                m_flush--;
            end else if (v && ref_taken(op, z, lt)) begin
                m_pending = 1'b1;
                m_target  = 16'((int'(pc) + int'(off)) % 65536);
                if (m_cnt_a < 65535) m_cnt_a++;
                if (m_cnt_b < 3)     m_cnt_b++;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
